frotaegis_readout_packer: RTL
=============================

// Module: frotaegis_readout_packer
// PURPOSE
//  Receiving end of the Fortaegis readout streams (FramEn/FramAdd/FramData, HistaEn/HistaAdd/HistaData).
//  Captures one complete readout (LENGTH frame samples, DATA_NUM histogram bins) into local buffers.
//  Then sends it as one byte packet over a valid/ready link: SOF, sequence, frame, histogram, checksum.
//  Sits between the collector/readout block and the host-side transport.
// PARAMETERS
//  DATA_SIZE    4   frame sample width; also histogram address width (DATA_NUM = 2**DATA_SIZE)
//  DATA_NUM    16   histogram bins per readout
//  LENGTH      64   frame samples per readout (= 2**LENGTH_SIZE)
//  LENGTH_SIZE  6   frame address width; also histogram bin value width
//  SOF      8'hA5   start-of-frame byte. DATA_SIZE and LENGTH_SIZE are both <= 8.
// PORTS
//  clk         in   1            single clock, all logic on rising edge
//  rstn        in   1            asynchronous active-low reset
//  FramEn      in   1            frame sample valid
//  FramAdd     in   LENGTH_SIZE  frame sample index 0..LENGTH-1
//  FramData    in   DATA_SIZE    frame sample
//  HistaEn     in   1            histogram bin valid
//  HistaAdd    in   DATA_SIZE    histogram bin index 0..DATA_NUM-1
//  HistaData   in   LENGTH_SIZE  histogram bin count
//  TxValid     out  1            TxData valid
//  TxReady     in   1            downstream accepts the byte
//  TxData      out  8            packet byte
//  TxLast      out  1            marks the checksum byte
//  Busy        out  1            high in every state other than IDLE
//  DropFrame   out  1            1-cycle pulse: readout started while packet still sending
//  ShortFrame  out  1            1-cycle pulse: capture ended incomplete, packet discarded
// BEHAVIOUR
//  Reset values: all outputs 0, state IDLE, Seq 8'h00.
//  Reset is asynchronous and can occur mid-packet. It aborts the packet with no checksum byte.
//  All outputs are registered.
//  States: IDLE -> CAPTURE -> HDR -> SEQ -> FRAME -> HIST -> CSUM -> IDLE.
//  IDLE: FramEn=1 or HistaEn=1 writes that sample, clears both valid masks, goes to CAPTURE.
//  CAPTURE
//   - FramEn=1 writes FrameBuf[FramAdd] and sets FMask bit.
//   - HistaEn=1 writes HistBuf[HistaAdd] and sets HMask bit. Both can occur in the same cycle.
//   - A repeated address overwrites the buffer entry; the mask bit stays 1.
//   - Capture ends in the first cycle with FramEn=0 and HistaEn=0.
//   - At that point, FMask and HMask all ones go to HDR. Otherwise ShortFrame pulses and the state goes to IDLE.
//  Send states: each state holds one byte until TxValid&TxReady, then advances to the next byte/state.
//   - HDR sends SOF. SEQ sends Seq.
//   - FRAME sends FrameBuf[0..LENGTH-1], zero-extended. HIST sends HistBuf[0..DATA_NUM-1], zero-extended.
//   - CSUM sends Csum with TxLast=1. On acceptance, Seq increments (wrap FF->00) and the state goes to IDLE.
//  Latency: TxValid=1 with SOF on the 2nd rising edge after the capture-end cycle.
//  Handshake
//   - TxData and TxLast are stable while TxValid=1 and TxReady=0.
//   - TxValid never drops before acceptance. TxReady is ignored when TxValid=0.
//   - Next byte is presented the cycle after acceptance, so back-to-back throughput is 1 byte/clk.
//  Checksum: Csum = 8-bit sum mod 256 of all bytes after SOF (Seq, frame bytes, hist bytes).
//   - Accumulated as each byte is accepted. Cleared on entry to HDR.
//  Inputs arriving with FramEn/HistaEn during HDR..CSUM
//   - The samples are ignored and the buffers are not written.
//   - DropFrame pulses once, on the first enable cycle of that burst. A burst is enable high after a cycle with both enables low.
//  After CSUM the block re-arms in IDLE. A burst already in progress when IDLE is entered is not captured.
//   - Capture waits for both enables low, then a rising enable.
//  Boundary conditions
//   - Address wrap at LENGTH-1 / DATA_NUM-1 is not used.
//   - Byte counters are LENGTH_SIZE / DATA_SIZE bits. Terminal counts are LENGTH-1 and DATA_NUM-1.
// STRUCTURE
//  Shared package frotaegis_pkg
//   - SOF constant.
//   - State encoding: IDLE, CAPTURE, HDR, SEQ, FRAME, HIST, CSUM.
//   - Packet length constant PKT_BYTES = LENGTH + DATA_NUM + 3.
//  Sub-module frotaegis_capture_buf
//   - Contains FrameBuf, HistBuf, FMask, HMask and async-read ports.
//   - The top level holds the FSM, counters, checksum and Tx registers.
// TESTING
//  1. Collector-style readout
//     - Stimulus: FramEn 64 cycles, FramAdd 0..63, FramData = addr&0xF. HistaEn 16 cycles starting 1 cycle later, HistaData = 4. TxReady=1.
//     - Required: 83 bytes A5,00,00..0F x4,04 x16,(sum=0x1E0+0x40)=0x20 with TxLast. Then Busy=0.
//  2. TxReady toggling 1-in-3 on the test-1 stream
//     - Required: identical byte sequence; TxData stable during every stall.
//  3. FramEn drops after 40 samples
//     - Required: ShortFrame single pulse, TxValid stays 0, state IDLE.
//  4. Second readout during packet send
//     - Required: DropFrame one pulse.
//     - Required: byte stream of the first packet unchanged.
//     - Required: the third readout goes out with Seq=01.
//  5. rstn low mid-FRAME with TxReady=0
//     - Required: TxValid=0 and TxLast=0 immediately. Next readout sends Seq=00.
//  6. 256 back-to-back packets
//     - Required: Seq wraps FF->00. Every Csum matches the model.

Source files
------------

// File: rtl/frotaegis_pkg.sv
// Shared constants and FSM encoding for the Fortaegis readout packer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package frotaegis_pkg;

    localparam int         FR_DATA_SIZE   = 4;
    localparam int         FR_DATA_NUM    = 16;
    localparam int         FR_LENGTH      = 64;
    localparam int         FR_LENGTH_SIZE = 6;

    // Start-of-frame byte leading every packet.
    localparam logic [7:0] PKT_SOF        = 8'hA5;

    // Full packet: SOF + Seq + frame bytes + histogram bytes + checksum.
    localparam int         PKT_BYTES      = FR_LENGTH + FR_DATA_NUM + 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_HDR,
        ST_SEQ,
        ST_FRAME,
        ST_HIST,
        ST_CSUM
    } state_t;

endpackage

// File: rtl/frotaegis_capture_buf.sv
// Frame/histogram capture storage with per-entry valid masks and async read ports.
// Latency: writes visible on the read ports the cycle after the write.
// Backpressure: none; writes are accepted whenever the write enables are high.
// Ports: clr wipes both masks (a write in the same cycle still sets its bit);
//        fram_*/hist_* write ports; *_rd_add/*_rd_dat combinational reads;
//        fmask_full/hmask_full flag that every entry has been written since clr.
module frotaegis_capture_buf
    import frotaegis_pkg::*;
#(
    parameter int DATA_SIZE   = FR_DATA_SIZE,
    parameter int DATA_NUM    = FR_DATA_NUM,
    parameter int LENGTH      = FR_LENGTH,
    parameter int LENGTH_SIZE = FR_LENGTH_SIZE
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   clr,
    input  logic                   fram_we,
    input  logic [LENGTH_SIZE-1:0] fram_add,
    input  logic [DATA_SIZE-1:0]   fram_dat,
    input  logic                   hist_we,
    input  logic [DATA_SIZE-1:0]   hist_add,
    input  logic [LENGTH_SIZE-1:0] hist_dat,
    input  logic [LENGTH_SIZE-1:0] frame_rd_add,
    output logic [DATA_SIZE-1:0]   frame_rd_dat,
    input  logic [DATA_SIZE-1:0]   hist_rd_add,
    output logic [LENGTH_SIZE-1:0] hist_rd_dat,
    output logic                   fmask_full,
    output logic                   hmask_full
);

    logic [DATA_SIZE-1:0]   frame_buf_q [LENGTH];
    logic [DATA_SIZE-1:0]   frame_buf_d [LENGTH];
    logic [LENGTH_SIZE-1:0] hist_buf_q  [DATA_NUM];
    logic [LENGTH_SIZE-1:0] hist_buf_d  [DATA_NUM];
    logic [LENGTH-1:0]      fmask_q, fmask_d;
    logic [DATA_NUM-1:0]    hmask_q, hmask_d;

    always_comb begin
        frame_buf_d = frame_buf_q;
        hist_buf_d  = hist_buf_q;
        fmask_d     = clr ? '0 : fmask_q;
        hmask_d     = clr ? '0 : hmask_q;
        if (fram_we) begin
            frame_buf_d[fram_add] = fram_dat;
            fmask_d[fram_add]     = 1'b1;
        end
        if (hist_we) begin
            hist_buf_d[hist_add] = hist_dat;
            hmask_d[hist_add]    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            frame_buf_q <= '{default: '0};
            hist_buf_q  <= '{default: '0};
            fmask_q     <= '0;
            hmask_q     <= '0;
        end else begin
            frame_buf_q <= frame_buf_d;
            hist_buf_q  <= hist_buf_d;
            fmask_q     <= fmask_d;
            hmask_q     <= hmask_d;
        end
    end

    assign frame_rd_dat = frame_buf_q[frame_rd_add];
    assign hist_rd_dat  = hist_buf_q[hist_rd_add];
    assign fmask_full   = &fmask_q;
    assign hmask_full   = &hmask_q;

endmodule

// File: rtl/frotaegis_readout_packer.sv
// Captures one Fortaegis readout (frame + histogram) and sends it as a byte packet.
// Latency: SOF valid on the 2nd rising edge after the capture-end cycle; 1 byte/clk when TxReady stays high.
// Backpressure: TxValid/TxReady; the byte and TxLast hold while stalled, readouts arriving mid-send are dropped.
// Ports: FramEn/FramAdd/FramData and HistaEn/HistaAdd/HistaData capture inputs;
//        TxValid/TxReady/TxData/TxLast packet link; Busy (not IDLE), DropFrame and ShortFrame event pulses.
module frotaegis_readout_packer
    import frotaegis_pkg::*;
#(
    parameter int         DATA_SIZE   = FR_DATA_SIZE,
    parameter int         DATA_NUM    = FR_DATA_NUM,
    parameter int         LENGTH      = FR_LENGTH,
    parameter int         LENGTH_SIZE = FR_LENGTH_SIZE,
    parameter logic [7:0] SOF         = PKT_SOF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   FramEn,
    input  logic [LENGTH_SIZE-1:0] FramAdd,
    input  logic [DATA_SIZE-1:0]   FramData,
    input  logic                   HistaEn,
    input  logic [DATA_SIZE-1:0]   HistaAdd,
    input  logic [LENGTH_SIZE-1:0] HistaData,
    output logic                   TxValid,
    input  logic                   TxReady,
    output logic [7:0]             TxData,
    output logic                   TxLast,
    output logic                   Busy,
    output logic                   DropFrame,
    output logic                   ShortFrame
);

    localparam logic [LENGTH_SIZE-1:0] F_LAST = LENGTH_SIZE'(LENGTH - 1);
    localparam logic [DATA_SIZE-1:0]   H_LAST = DATA_SIZE'(DATA_NUM - 1);

    state_t                 state_q, state_d;
    logic [LENGTH_SIZE-1:0] fcnt_q, fcnt_d;
    logic [DATA_SIZE-1:0]   hcnt_q, hcnt_d;
    logic [7:0]             csum_q, csum_d;
    logic [7:0]             seq_q, seq_d;
    logic                   tx_vld_q, tx_vld_d;
    logic [7:0]             tx_dat_q, tx_dat_d;
    logic                   tx_last_q, tx_last_d;
    logic                   busy_q, busy_d;
    logic                   drop_q, drop_d;
    logic                   short_q, short_d;
    logic                   en_prev_q, en_prev_d;

    logic                   any_en, start, accept, in_send, cap_we;
    logic [LENGTH_SIZE-1:0] frame_rd_add;
    logic [DATA_SIZE-1:0]   frame_rd_dat;
    logic [DATA_SIZE-1:0]   hist_rd_add;
    logic [LENGTH_SIZE-1:0] hist_rd_dat;
    logic                   fmask_full, hmask_full;

    // A capture only starts on a fresh burst: enables low the cycle before.
    assign any_en  = FramEn | HistaEn;
    assign start   = (state_q == ST_IDLE) && any_en && !en_prev_q;
    assign accept  = tx_vld_q && TxReady;
    assign in_send = (state_q != ST_IDLE) && (state_q != ST_CAPTURE);
    assign cap_we  = start || (state_q == ST_CAPTURE);

    // Read addresses point at the byte to be loaded after the current one is accepted.
    assign frame_rd_add = (state_q == ST_FRAME) ? fcnt_q + LENGTH_SIZE'(1) : '0;
    assign hist_rd_add  = (state_q == ST_HIST)  ? hcnt_q + DATA_SIZE'(1)   : '0;

    frotaegis_capture_buf #(
        .DATA_SIZE   (DATA_SIZE),
        .DATA_NUM    (DATA_NUM),
        .LENGTH      (LENGTH),
        .LENGTH_SIZE (LENGTH_SIZE)
    ) u_buf (
        .clk          (clk),
        .rstn         (rstn),
        .clr          (start),
        .fram_we      (cap_we && FramEn),
        .fram_add     (FramAdd),
        .fram_dat     (FramData),
        .hist_we      (cap_we && HistaEn),
        .hist_add     (HistaAdd),
        .hist_dat     (HistaData),
        .frame_rd_add (frame_rd_add),
        .frame_rd_dat (frame_rd_dat),
        .hist_rd_add  (hist_rd_add),
        .hist_rd_dat  (hist_rd_dat),
        .fmask_full   (fmask_full),
        .hmask_full   (hmask_full)
    );

    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        hcnt_d    = hcnt_q;
        csum_d    = csum_q;
        seq_d     = seq_q;
        tx_vld_d  = tx_vld_q;
        tx_dat_d  = tx_dat_q;
        tx_last_d = tx_last_q;
        drop_d    = in_send && any_en && !en_prev_q;
        short_d   = 1'b0;
        en_prev_d = any_en;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (!any_en) begin
                    if (fmask_full && hmask_full) begin
                        state_d = ST_HDR;
                        csum_d  = 8'h00;
                    end else begin
                        short_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_HDR: begin
                // First HDR cycle only loads SOF; this is the extra cycle of latency.
                if (!tx_vld_q) begin
                    tx_vld_d = 1'b1;
                    tx_dat_d = SOF;
                end else if (TxReady) begin
                    tx_dat_d = seq_q;
                    state_d  = ST_SEQ;
                end
            end
            ST_SEQ: begin
                if (accept) begin
                    csum_d   = csum_q + tx_dat_q;
                    fcnt_d   = '0;
                    tx_dat_d = 8'(frame_rd_dat);
                    state_d  = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (accept) begin
                    csum_d = csum_q + tx_dat_q;
                    if (fcnt_q == F_LAST) begin
                        hcnt_d   = '0;
                        tx_dat_d = 8'(hist_rd_dat);
                        state_d  = ST_HIST;
                    end else begin
                        fcnt_d   = fcnt_q + LENGTH_SIZE'(1);
                        tx_dat_d = 8'(frame_rd_dat);
                    end
                end
            end
            ST_HIST: begin
                if (accept) begin
                    csum_d = csum_q + tx_dat_q;
                    if (hcnt_q == H_LAST) begin
                        tx_dat_d  = csum_q + tx_dat_q;
                        tx_last_d = 1'b1;
                        state_d   = ST_CSUM;
                    end else begin
                        hcnt_d   = hcnt_q + DATA_SIZE'(1);
                        tx_dat_d = 8'(hist_rd_dat);
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    tx_vld_d  = 1'b0;
                    tx_last_d = 1'b0;
                    tx_dat_d  = 8'h00;
                    seq_d     = seq_q + 8'd1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            fcnt_q    <= '0;
            hcnt_q    <= '0;
            csum_q    <= 8'h00;
            seq_q     <= 8'h00;
            tx_vld_q  <= 1'b0;
            tx_dat_q  <= 8'h00;
            tx_last_q <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
            short_q   <= 1'b0;
            en_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            hcnt_q    <= hcnt_d;
            csum_q    <= csum_d;
            seq_q     <= seq_d;
            tx_vld_q  <= tx_vld_d;
            tx_dat_q  <= tx_dat_d;
            tx_last_q <= tx_last_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
            short_q   <= short_d;
            en_prev_q <= en_prev_d;
        end
    end

    assign TxValid    = tx_vld_q;
    assign TxData     = tx_dat_q;
    assign TxLast     = tx_last_q;
    assign Busy       = busy_q;
    assign DropFrame  = drop_q;
    assign ShortFrame = short_q;

endmodule
